// File: rtl/lzd_shift_sequencer_if.sv
// Handshake bundle for lzd_shift_sequencer.
//   master : drives start/target/mode/abort, observes status (controller side)
//   slave  : the sequencer itself
// Signals:
//   start    - request a new shift sequence
//   target   - unsigned shift target (WIDTH bits)
//   mode     - 0: run while count < target, 1: run while count <= target
//   abort    - cancel an active sequence
//   busy     - sequence running
//   shift_en - one-cycle shift strobe for the datapath
//   count    - shifts issued in the current/last sequence
//   cmp      - live compare of count against latched target
//   done     - one-cycle completion pulse
interface lzd_shift_sequencer_if #(
  parameter int WIDTH = 5
);
  logic             start;
  logic [WIDTH-1:0] target;
  logic             mode;
  logic             abort;
  logic             busy;
  logic             shift_en;
  logic [WIDTH-1:0] count;
  logic             cmp;
  logic             done;

  modport master (
    output start, target, mode, abort,
    input  busy, shift_en, count, cmp, done
  );

  modport slave (
    input  start, target, mode, abort,
    output busy, shift_en, count, cmp, done
  );
endinterface

// File: rtl/lzd_shift_sequencer.sv
// Sequential shift controller for the normalisation path. Once started it
// issues one shift_en strobe per cycle while the internal counter compares
// below (or, in inclusive mode, at most equal to) the latched target, then
// pulses done for one cycle. The counter saturates at all-ones instead of
// wrapping. abort cancels a running sequence without a done pulse.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - lzd_shift_sequencer_if slave modport (start/target/mode/abort in,
//           busy/shift_en/count/cmp/done out)
module lzd_shift_sequencer #(
  parameter int WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lzd_shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lt, eq, cmp;

  // MSB-first unsigned compare: a < b wherever a has 0 and b has 1 at the
  // first differing bit. Returns {less_than, equal}.
  function automatic logic [1:0] compare_lt_eq(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic eq_above;
    logic lt_acc;
    eq_above = 1'b1;
    lt_acc   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      lt_acc   = lt_acc | (~a[i] & b[i] & eq_above);
      eq_above = eq_above & ~(a[i] ^ b[i]);
    end
    return {lt_acc, eq_above};
  endfunction

  always_comb begin
    {lt, eq} = compare_lt_eq(count_q, tgt_q);
    cmp      = lt | (mode_q & eq);
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tgt_d   = tgt_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          tgt_d   = bus.target;
          mode_d  = bus.mode;
          count_d = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (cmp) begin
          // Inclusive all-ones target: last shift happens at CNT_MAX, hold it.
          if (count_q == CNT_MAX) state_d = S_DONE;
          else                    count_d = count_q + CNT_ONE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      tgt_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tgt_q   <= tgt_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // abort suppresses the strobe in the cycle it is raised.
  assign bus.shift_en = busy_q & cmp & ~bus.abort;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.count    = count_q;
  assign bus.cmp      = cmp;

endmodule

// File: tb/tb_lzd_shift_sequencer.sv
module tb_lzd_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, mode;
  logic [7:0] target;
  int         sel;

  always #5 clk = ~clk;

  lzd_shift_sequencer_if #(.WIDTH(4)) if4 ();
  lzd_shift_sequencer_if #(.WIDTH(5)) if5 ();
  lzd_shift_sequencer_if #(.WIDTH(8)) if8 ();

  assign if4.start  = start && (sel == 4);
  assign if4.abort  = abort && (sel == 4);
  assign if4.mode   = mode;
  assign if4.target = target[3:0];
  assign if5.start  = start && (sel == 5);
  assign if5.abort  = abort && (sel == 5);
  assign if5.mode   = mode;
  assign if5.target = target[4:0];
  assign if8.start  = start && (sel == 8);
  assign if8.abort  = abort && (sel == 8);
  assign if8.mode   = mode;
  assign if8.target = target;

  lzd_shift_sequencer #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  lzd_shift_sequencer #(.WIDTH(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5.slave));
  lzd_shift_sequencer #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  logic       obs_busy, obs_shift_en, obs_done, obs_cmp;
  logic [7:0] obs_count;

  always_comb begin
    obs_busy = if5.busy; obs_shift_en = if5.shift_en; obs_done = if5.done;
    obs_cmp  = if5.cmp;  obs_count = {3'b000, if5.count};
    case (sel)
      4: begin
        obs_busy = if4.busy; obs_shift_en = if4.shift_en; obs_done = if4.done;
        obs_cmp  = if4.cmp;  obs_count = {4'b0000, if4.count};
      end
      8: begin
        obs_busy = if8.busy; obs_shift_en = if8.shift_en; obs_done = if8.done;
        obs_cmp  = if8.cmp;  obs_count = if8.count;
      end
      default: ;
    endcase
  end

  typedef struct {
    int n;     // shifts
    int cnt;   // count value while done is high
    int dcyc;  // cycle index of done (cycle 0 = first cycle after start edge)
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  // Reference: exclusive runs target shifts, inclusive target+1 capped at 2^w.
  function automatic exp_t model(input int w, input int tgt, input bit m);
    exp_t e;
    int   maxv;
    maxv = (1 << w) - 1;
    if (!m) begin
      e.n = tgt; e.cnt = tgt; e.dcyc = tgt + 1;
    end else if (tgt == maxv) begin
      e.n = maxv + 1; e.cnt = maxv; e.dcyc = maxv + 1;
    end else begin
      e.n = tgt + 1; e.cnt = tgt + 1; e.dcyc = tgt + 2;
    end
    return e;
  endfunction

  // Called at a sample point; the start is captured by the next rising edge.
  // Returns at the sample point of cycle 0 of the new sequence.
  task automatic drive_start(input int w, input logic [7:0] tgt, input logic m);
    sel    = w;
    start  = 1'b1;
    target = tgt;
    mode   = m;
    @(negedge clk); #1;
    start  = 1'b0;
  endtask

  // Watches the selected DUT until done or budget; optionally issues a
  // back-to-back start in the done cycle.
  task automatic observe(input int budget, input bit restart, input logic [7:0] rtgt,
                         input logic rmode, output int shifts, output int cycles,
                         output bit saw, output int cnt);
    shifts = 0; cycles = 0; saw = 1'b0; cnt = -1;
    while (cycles < budget) begin
      if (obs_shift_en === 1'b1) shifts++;
      if (obs_done === 1'b1) begin
        saw = 1'b1;
        cnt = int'(obs_count);
        if (restart) begin
          start = 1'b1; target = rtgt; mode = rmode;
        end
        break;
      end
      @(negedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    int w;
    #2;
    for (int k = 0; k < 3; k++) begin
      w = (k == 0) ? 4 : ((k == 1) ? 5 : 8);
      sel = w;
      #1;
      n_cmp++; if (obs_busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy w%0d: got %b want 0", w, obs_busy); end
      n_cmp++; if (obs_shift_en !== 1'b0) begin n_mis++; $display("FAIL reset_shift_en w%0d: got %b want 0", w, obs_shift_en); end
      n_cmp++; if (obs_done !== 1'b0) begin n_mis++; $display("FAIL reset_done w%0d: got %b want 0", w, obs_done); end
      n_cmp++; if (obs_count !== 8'd0) begin n_mis++; $display("FAIL reset_count w%0d: got %0d want 0", w, obs_count); end
      n_cmp++; if (obs_cmp !== 1'b0) begin n_mis++; $display("FAIL reset_cmp w%0d: got %b want 0", w, obs_cmp); end
    end
    sel = 5;
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (obs_busy !== 1'b0) begin n_mis++; $display("FAIL post_reset_idle: busy got %b want 0", obs_busy); end
  endtask

  task automatic test_reset_mid_run();
    bit saw;
    drive_start(5, 8'd20, 1'b0);
    for (int c = 0; c < 30 && obs_count != 8'd7; c++) begin
      @(negedge clk); #1;
    end
    n_cmp++; if (obs_count !== 8'd7 || obs_shift_en !== 1'b1) begin n_mis++; $display("FAIL midrst_reach: count %0d shift_en %b want 7/1", obs_count, obs_shift_en); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (obs_busy !== 1'b0) begin n_mis++; $display("FAIL midrst_busy: got %b want 0", obs_busy); end
    n_cmp++; if (obs_shift_en !== 1'b0) begin n_mis++; $display("FAIL midrst_shift_en: got %b want 0", obs_shift_en); end
    n_cmp++; if (obs_count !== 8'd0) begin n_mis++; $display("FAIL midrst_count: got %0d want 0", obs_count); end
    n_cmp++; if (obs_done !== 1'b0) begin n_mis++; $display("FAIL midrst_done: got %b want 0", obs_done); end
    saw = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      if (obs_done === 1'b1 || obs_busy === 1'b1) saw = 1'b1;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      if (obs_done === 1'b1 || obs_busy === 1'b1) saw = 1'b1;
    end
    n_cmp++; if (saw !== 1'b0) begin n_mis++; $display("FAIL midrst_stays_idle: activity seen %b want 0", saw); end
  endtask

  task automatic test_basic();
    int sh, cy, ct; bit saw; exp_t e;
    exp_q.push_back(model(5, 6, 1'b0));
    drive_start(5, 8'd6, 1'b0);
    n_cmp++; if (obs_busy !== 1'b1 || obs_count !== 8'd0) begin n_mis++; $display("FAIL basic_cycle0: busy %b count %0d want 1/0", obs_busy, obs_count); end
    observe(60, 1'b0, 8'd0, 1'b0, sh, cy, saw, ct);
    e = exp_q.pop_front();
    n_cmp++; if (saw !== 1'b1) begin n_mis++; $display("FAIL basic_done_seen: got %b want 1", saw); end
    n_cmp++; if (sh !== e.n) begin n_mis++; $display("FAIL basic_shifts: got %0d want %0d", sh, e.n); end
    n_cmp++; if (ct !== e.cnt) begin n_mis++; $display("FAIL basic_count: got %0d want %0d", ct, e.cnt); end
    n_cmp++; if (cy !== e.dcyc) begin n_mis++; $display("FAIL basic_latency: got %0d want %0d", cy, e.dcyc); end
    @(negedge clk); #1;
    n_cmp++; if (obs_done !== 1'b0 || obs_busy !== 1'b0) begin n_mis++; $display("FAIL basic_done_pulse: done %b busy %b want 0/0", obs_done, obs_busy); end
    n_cmp++; if (obs_count !== 8'd6) begin n_mis++; $display("FAIL basic_count_hold: got %0d want 6", obs_count); end
  endtask

  task automatic run_table(input string name, input int w, input int len,
                           input int tgts[4], input bit modes[4]);
    int sh, cy, ct; bit saw; exp_t e;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(model(w, tgts[i], modes[i]));
      drive_start(w, 8'(tgts[i]), modes[i]);
      observe(300, 1'b0, 8'd0, 1'b0, sh, cy, saw, ct);
      e = exp_q.pop_front();
      n_cmp++; if (saw !== 1'b1) begin n_mis++; $display("FAIL %s_done_seen[%0d]: got %b want 1", name, i, saw); end
      n_cmp++; if (sh !== e.n) begin n_mis++; $display("FAIL %s_shifts[%0d]: got %0d want %0d", name, i, sh, e.n); end
      n_cmp++; if (ct !== e.cnt) begin n_mis++; $display("FAIL %s_count[%0d]: got %0d want %0d", name, i, ct, e.cnt); end
      n_cmp++; if (cy !== e.dcyc) begin n_mis++; $display("FAIL %s_latency[%0d]: got %0d want %0d", name, i, cy, e.dcyc); end
      @(negedge clk); #1;
      n_cmp++; if (obs_done !== 1'b0 || int'(obs_count) !== e.cnt) begin n_mis++; $display("FAIL %s_after_done[%0d]: done %b count %0d want 0/%0d", name, i, obs_done, obs_count, e.cnt); end
    end
  endtask

  task automatic test_zero_inclusive();
    int  t[4] = '{0, 0, 30, 31};
    bit  m[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    run_table("zero_incl", 5, 4, t, m);
  endtask

  task automatic test_saturation();
    int  t[4] = '{15, 14, 15, 0};
    bit  m[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    run_table("sat", 4, 3, t, m);
  endtask

  task automatic test_abort();
    int sh; bit saw;
    sh = 0; saw = 1'b0;
    drive_start(5, 8'd10, 1'b0);
    for (int c = 0; c < 12; c++) begin
      if (c == 3) begin start = 1'b1; target = 8'd2; end
      else start = 1'b0;
      if (c == 4) begin
        abort = 1'b1;
        #1;
        n_cmp++; if (obs_shift_en !== 1'b0) begin n_mis++; $display("FAIL abort_shift_en: got %b want 0", obs_shift_en); end
        n_cmp++; if (obs_cmp !== 1'b1) begin n_mis++; $display("FAIL abort_target_kept: cmp got %b want 1", obs_cmp); end
      end else begin
        abort = 1'b0;
      end
      if (obs_shift_en === 1'b1) sh++;
      if (obs_done === 1'b1) saw = 1'b1;
      @(negedge clk); #1;
    end
    abort = 1'b0; start = 1'b0;
    n_cmp++; if (sh !== 4) begin n_mis++; $display("FAIL abort_shifts: got %0d want 4", sh); end
    n_cmp++; if (saw !== 1'b0) begin n_mis++; $display("FAIL abort_no_done: got %b want 0", saw); end
    n_cmp++; if (obs_busy !== 1'b0) begin n_mis++; $display("FAIL abort_idle: busy got %b want 0", obs_busy); end
    n_cmp++; if (obs_count !== 8'd4) begin n_mis++; $display("FAIL abort_count: got %0d want 4", obs_count); end
  endtask

  task automatic test_back_to_back();
    int sh, cy, ct, total; bit saw; exp_t e;
    exp_q.push_back(model(5, 3, 1'b0));
    exp_q.push_back(model(5, 9, 1'b0));
    drive_start(5, 8'd3, 1'b0);
    observe(60, 1'b1, 8'd9, 1'b0, sh, cy, saw, ct);
    e = exp_q.pop_front();
    n_cmp++; if (saw !== 1'b1 || sh !== e.n || ct !== e.cnt || cy !== e.dcyc) begin n_mis++; $display("FAIL b2b_first: saw %b shifts %0d count %0d cyc %0d want 1/%0d/%0d/%0d", saw, sh, ct, cy, e.n, e.cnt, e.dcyc); end
    total = sh;
    @(negedge clk); #1;
    start = 1'b0;
    n_cmp++; if (obs_shift_en !== 1'b1 || obs_count !== 8'd0) begin n_mis++; $display("FAIL b2b_no_gap: shift_en %b count %0d want 1/0", obs_shift_en, obs_count); end
    observe(60, 1'b0, 8'd0, 1'b0, sh, cy, saw, ct);
    e = exp_q.pop_front();
    n_cmp++; if (saw !== 1'b1 || sh !== e.n || ct !== e.cnt || cy !== e.dcyc) begin n_mis++; $display("FAIL b2b_second: saw %b shifts %0d count %0d cyc %0d want 1/%0d/%0d/%0d", saw, sh, ct, cy, e.n, e.cnt, e.dcyc); end
    total += sh;
    n_cmp++; if (total !== 12) begin n_mis++; $display("FAIL b2b_total: got %0d want 12", total); end
  endtask

  task automatic test_width8_sweep();
    int sh, cy, ct, t; bit saw, m; exp_t e;
    for (int i = 0; i < 10; i++) begin
      t = (i == 0) ? 255 : int'($urandom_range(0, 255));
      m = (i == 0) ? 1'b1 : 1'(int'($urandom_range(0, 1)));
      exp_q.push_back(model(8, t, m));
      // back-to-back: the start lands in the previous sequence's done cycle
      drive_start(8, 8'(t), m);
      observe(300, 1'b0, 8'd0, 1'b0, sh, cy, saw, ct);
      if (exp_q.size() == 0) begin
        n_cmp++; n_mis++; $display("FAIL w8_scoreboard_empty[%0d]: got 0 entries want 1", i);
      end else begin
        e = exp_q.pop_front();
        n_cmp++; if (saw !== 1'b1 || sh !== e.n || ct !== e.cnt || cy !== e.dcyc) begin n_mis++; $display("FAIL w8_seq[%0d] t=%0d m=%0d: saw %b shifts %0d count %0d cyc %0d want 1/%0d/%0d/%0d", i, t, m, saw, sh, ct, cy, e.n, e.cnt, e.dcyc); end
      end
    end
    @(negedge clk); #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    mode   = 1'b0;
    target = 8'd0;
    sel    = 5;
    test_reset();
    test_reset_mid_run();
    test_basic();
    test_zero_inclusive();
    test_saturation();
    test_abort();
    test_back_to_back();
    test_width8_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
